// File: rtl/fifo_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_bus_ctrl_if
//
// Purpose:
//    Groups the handshake signals around the FIFO bus controller. There are
//    three groups: the two write producers, the read consumer, and the strobe
//    and status lines of the external FIFO. The shared FIFO data bus (IO) is
//    not carried here. It stays a plain inout port on the controller, so the
//    tri-state driver lives in exactly one place.
//
// Signals (direction as seen from the controller / master side):
//    Clr            in   level request to re-initialise the FIFO
//    Req0, Req1     in   level write requests from producers 0 and 1
//    Data0, Data1   in   write data of producers 0 and 1 (DW bits)
//    Gnt0, Gnt1     out  one-cycle pulse: the producer's word is written now
//    Rd_req         in   level read request from the consumer
//    Rd_data        out  registered read word (DW bits)
//    Rd_valid       out  one-cycle valid pulse for Rd_data
//    RW             out  1 = write cycle, controller drives IO
//    RW1            out  FIFO access strobe
//    Load           out  FIFO pointer initialisation
//    Empty, Full    in   FIFO status flags
//    Busy           out  high whenever the controller is not idle
//
// Modports:
//    master  - the controller (fifo_bus_ctrl)
//    slave   - the environment: producers, consumer and FIFO status
// -----------------------------------------------------------------------------
interface fifo_bus_ctrl_if #(
   parameter int DW = 8
);

   logic          Clr;
   logic          Req0;
   logic          Req1;
   logic [DW-1:0] Data0;
   logic [DW-1:0] Data1;
   logic          Gnt0;
   logic          Gnt1;
   logic          Rd_req;
   logic [DW-1:0] Rd_data;
   logic          Rd_valid;
   logic          RW;
   logic          RW1;
   logic          Load;
   logic          Empty;
   logic          Full;
   logic          Busy;

   modport master (
      input  Clr,
      input  Req0,
      input  Req1,
      input  Data0,
      input  Data1,
      output Gnt0,
      output Gnt1,
      input  Rd_req,
      output Rd_data,
      output Rd_valid,
      output RW,
      output RW1,
      output Load,
      input  Empty,
      input  Full,
      output Busy
   );

   modport slave (
      output Clr,
      output Req0,
      output Req1,
      output Data0,
      output Data1,
      input  Gnt0,
      input  Gnt1,
      output Rd_req,
      input  Rd_data,
      input  Rd_valid,
      input  RW,
      input  RW1,
      input  Load,
      output Empty,
      output Full,
      input  Busy
   );

endinterface

// File: rtl/fifo_bus_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_bus_ctrl
//
// Purpose:
//    Arbitrates two write producers and one read consumer onto a single
//    external FIFO that has a shared bidirectional data bus.
//    - Writes take one bus cycle (WRITE).
//    - Reads take three cycles (READ, CAP, TURN). READ issues the strobe.
//      At the end of CAP the returned word is registered. TURN is a dead
//      cycle, so the FIFO can release the bus before the controller drives
//      it again.
//    - After reset, or on a Clr request, the controller spends one cycle in
//      INIT and pulses Load to re-initialise the FIFO pointers.
//
// Ports:
//    Clk     in     single clock; all state changes on its rising edge
//    Rst_n   in     asynchronous active-low reset
//    bus     master handshake and status signals (see fifo_bus_ctrl_if)
//    IO      inout  shared FIFO data bus, driven only while RW=1
//
// Parameters:
//    DW      data width of the FIFO bus and of all data ports
// -----------------------------------------------------------------------------
module fifo_bus_ctrl #(
   parameter int DW = 8
) (
   input  logic            Clk,
   input  logic            Rst_n,
   fifo_bus_ctrl_if.master bus,
   inout  wire  [DW-1:0]   IO
);

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      IDLE  = 3'd1,
      WRITE = 3'd2,
      READ  = 3'd3,
      CAP   = 3'd4,
      TURN  = 3'd5
   } state_t;

   state_t        state;
   state_t        state_nxt;

   // rr_ptr names the producer that wins when both request.
   // turn_rd set means a read wins when both kinds of work are pending.
   logic          rr_ptr;
   logic          rr_nxt;
   logic          turn_rd;
   logic          turn_nxt;

   // Producer chosen in IDLE. Its request and data are used in WRITE.
   logic          wr_sel;
   logic          sel_nxt;

   logic          wr_cand;
   logic          rd_cand;
   logic          pick;
   logic          wr_live;
   logic [DW-1:0] wr_data;

   logic          load_int;
   logic          rw_int;
   logic          rw1_int;
   logic          gnt0_int;
   logic          gnt1_int;

   logic [DW-1:0] rd_data_q;
   logic          rd_valid_q;

   // Candidate evaluation for the IDLE decision.
   // Requests blocked by Full or Empty simply do not form a candidate.
   // Because requests are levels, a blocked request stays pending until the
   // blocking flag clears.
   // With only one producer requesting, that producer is picked.
   // With both requesting, the round-robin pointer decides.
   assign wr_cand = !bus.Full && (bus.Req0 || bus.Req1);
   assign rd_cand = !bus.Empty && bus.Rd_req;
   assign pick    = (bus.Req0 && bus.Req1) ? rr_ptr : bus.Req1;

   // In WRITE the chosen producer must still be requesting.
   // If it withdrew after the decision, the cycle passes silently:
   // no strobe, no grant, and no change to the arbitration history.
   assign wr_live = wr_sel ? bus.Req1 : bus.Req0;
   assign wr_data = wr_sel ? bus.Data1 : bus.Data0;

   // State and arbitration history registers.
   // Reset puts the FSM into INIT, so the first cycle after release always
   // pulses Load and the FIFO is cleared after every reset.
   // Reset also sets producer 0 first and write-first for the turn bit.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state   <= INIT;
         rr_ptr  <= 1'b0;
         turn_rd <= 1'b0;
         wr_sel  <= 1'b0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_nxt;
         turn_rd <= turn_nxt;
         wr_sel  <= sel_nxt;
      end
   end

   // Next-state and strobe decode.
   // All decisions happen in IDLE. Clr has priority there, then the
   // read/write choice. Clr seen in any other state is ignored, so a running
   // operation always completes; a Clr that is still held is acted on at the
   // next IDLE.
   // In READ the consumer must still be requesting. Otherwise the read is
   // abandoned without a strobe and the bus was never turned around.
   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_ptr;
      turn_nxt  = turn_rd;
      sel_nxt   = wr_sel;
      load_int  = 1'b0;
      rw_int    = 1'b0;
      rw1_int   = 1'b0;
      gnt0_int  = 1'b0;
      gnt1_int  = 1'b0;

      case (state)
         INIT: begin
            load_int  = 1'b1;
            state_nxt = IDLE;
         end

         IDLE: begin
            if (bus.Clr) begin
               state_nxt = INIT;
            end else if (wr_cand && (!rd_cand || !turn_rd)) begin
               state_nxt = WRITE;
               sel_nxt   = pick;
            end else if (rd_cand) begin
               state_nxt = READ;
            end
         end

         WRITE: begin
            state_nxt = IDLE;
            if (wr_live) begin
               rw_int   = 1'b1;
               rw1_int  = 1'b1;
               gnt0_int = !wr_sel;
               gnt1_int = wr_sel;
               rr_nxt   = !wr_sel;
               turn_nxt = 1'b1;
            end
         end

         READ: begin
            if (bus.Rd_req) begin
               rw1_int   = 1'b1;
               turn_nxt  = 1'b0;
               state_nxt = CAP;
            end else begin
               state_nxt = IDLE;
            end
         end

         CAP: begin
            state_nxt = TURN;
         end

         TURN: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = INIT;
         end
      endcase
   end

   // Read capture.
   // The FIFO drives IO during CAP, and the word is sampled on CAP's closing
   // edge. Rd_valid is a single-cycle pulse that lines up with TURN.
   // An asynchronous reset in the middle of a read clears both registers,
   // so an aborted read never produces a valid pulse.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= (state == CAP);
         if (state == CAP) begin
            rd_data_q <= IO;
         end
      end
   end

   // Tri-state bus driver. Only a live write cycle enables it.
   assign IO = rw_int ? wr_data : {DW{1'bz}};

   // Output hookup.
   // The state register holds INIT while Rst_n is low. Load is therefore
   // qualified with Rst_n, so it can only pulse after reset is released.
   assign bus.Load     = load_int & Rst_n;
   assign bus.RW       = rw_int;
   assign bus.RW1      = rw1_int;
   assign bus.Gnt0     = gnt0_int;
   assign bus.Gnt1     = gnt1_int;
   assign bus.Rd_data  = rd_data_q;
   assign bus.Rd_valid = rd_valid_q;
   assign bus.Busy     = (state != IDLE);

endmodule

// File: tb/tb_fifo_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_bus_ctrl
//
// Purpose:
//    Directed, self-checking bench for fifo_bus_ctrl.
//    - A table of per-cycle records holds the inputs and the hand-computed
//      outputs. Each record is applied on a falling edge and checked 1 ns
//      later.
//    - Hand-written sequences cover the reset and Clr corner cases.
//    - A small FIFO model drives IO only when asked to, and only while the
//      controller is not driving.
// -----------------------------------------------------------------------------
module tb_fifo_bus_ctrl;

   localparam int DW = 8;

   logic          Clk;
   logic          Rst_n;
   wire  [DW-1:0] io_bus;
   logic          fifo_drv;
   logic [DW-1:0] fifo_word;

   int            n_compared;
   int            n_mismatched;

   fifo_bus_ctrl_if #(.DW(DW)) bus_if ();

   fifo_bus_ctrl #(.DW(DW)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus_if),
      .IO    (io_bus)
   );

   // FIFO side of the shared bus: it returns a word only when the
   // controller is not driving.
   assign io_bus = (fifo_drv && !bus_if.RW) ? fifo_word : {DW{1'bz}};

   // Free-running clock, period 10.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Per-cycle record.
   // flags = {Gnt0, Gnt1, RW, RW1, Load, Busy, Rd_valid}.
   // io is compared only when RW is expected high.
   typedef struct {
      logic          clr;
      logic          req0;
      logic          req1;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic          rd_req;
      logic          empty;
      logic          full;
      logic          fdrv;
      logic [DW-1:0] fword;
      logic [6:0]    flags;
      logic [DW-1:0] rdd;
      logic [DW-1:0] io;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t row(input logic clr, req0, req1,
                                input logic [DW-1:0] d0, d1,
                                input logic rd_req, empty, full, fdrv,
                                input logic [DW-1:0] fword,
                                input logic [6:0] flags,
                                input logic [DW-1:0] rdd, io);
      vec_t v;
      v.clr = clr;  v.req0 = req0;  v.req1 = req1;  v.d0 = d0;  v.d1 = d1;
      v.rd_req = rd_req;  v.empty = empty;  v.full = full;
      v.fdrv = fdrv;  v.fword = fword;
      v.flags = flags;  v.rdd = rdd;  v.io = io;
      return v;
   endfunction

   // Single comparison with bookkeeping.
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drives one record's inputs onto the interface and the FIFO model.
   task automatic applyStimulus(input vec_t v);
      bus_if.Clr    = v.clr;
      bus_if.Req0   = v.req0;
      bus_if.Req1   = v.req1;
      bus_if.Data0  = v.d0;
      bus_if.Data1  = v.d1;
      bus_if.Rd_req = v.rd_req;
      bus_if.Empty  = v.empty;
      bus_if.Full   = v.full;
      fifo_drv      = v.fdrv;
      fifo_word     = v.fword;
   endtask

   // Compares one record's expected outputs against the DUT.
   task automatic checkOutput(input vec_t v, input int idx);
      check($sformatf("row%0d_flags", idx),
            {25'd0, bus_if.Gnt0, bus_if.Gnt1, bus_if.RW, bus_if.RW1,
             bus_if.Load, bus_if.Busy, bus_if.Rd_valid},
            {25'd0, v.flags});
      check($sformatf("row%0d_rd_data", idx), {24'd0, bus_if.Rd_data}, {24'd0, v.rdd});
      if (v.flags[4]) begin
         check($sformatf("row%0d_io", idx), {24'd0, io_bus}, {24'd0, v.io});
      end
   endtask

   task automatic idleInputs();
      bus_if.Clr    = 1'b0;
      bus_if.Req0   = 1'b0;
      bus_if.Req1   = 1'b0;
      bus_if.Data0  = '0;
      bus_if.Data1  = '0;
      bus_if.Rd_req = 1'b0;
      bus_if.Empty  = 1'b1;
      bus_if.Full   = 1'b0;
      fifo_drv      = 1'b0;
      fifo_word     = '0;
   endtask

   // Reset entry and release.
   // While reset is held, every strobe is low and Busy is high.
   // Release on a falling edge: Load must be high for that one cycle, then
   // the controller must be idle.
   task automatic doReset();
      Rst_n = 1'b0;
      idleInputs();
      @(negedge Clk);
      @(negedge Clk);
      #1;
      check("rst_flags",
            {25'd0, bus_if.Gnt0, bus_if.Gnt1, bus_if.RW, bus_if.RW1,
             bus_if.Load, bus_if.Busy, bus_if.Rd_valid},
            {25'd0, 7'b0000010});
      check("rst_rd_data", {24'd0, bus_if.Rd_data}, 32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      #1;
      check("rel_load_hi", {31'd0, bus_if.Load}, 32'd1);
      check("rel_rw_lo", {31'd0, bus_if.RW}, 32'd0);
      @(negedge Clk);
      #1;
      check("rel_load_lo", {31'd0, bus_if.Load}, 32'd0);
      check("rel_idle", {31'd0, bus_if.Busy}, 32'd0);
   endtask

   // Watchdog: the run is fixed-length, so this only fires if time stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      n_compared   = 0;
      n_mismatched = 0;

      // Cycle table: clr r0 r1 d0 d1 rdreq empty full fdrv fword | flags rdd io
      // Two producers with both requests held: alternating writes 0A, 0C, 0A.
      tbl.push_back(row(0,1,1,8'h0A,8'h0C,0,1,0,0,8'h00, 7'b0000000,8'h00,8'h00));
      tbl.push_back(row(0,1,1,8'h0A,8'h0C,0,1,0,0,8'h00, 7'b1011010,8'h00,8'h0A));
      tbl.push_back(row(0,1,1,8'h0A,8'h0C,0,1,0,0,8'h00, 7'b0000000,8'h00,8'h00));
      tbl.push_back(row(0,1,1,8'h0A,8'h0C,0,1,0,0,8'h00, 7'b0111010,8'h00,8'h0C));
      tbl.push_back(row(0,1,1,8'h0A,8'h0C,0,1,0,0,8'h00, 7'b0000000,8'h00,8'h00));
      tbl.push_back(row(0,1,1,8'h0A,8'h0C,0,1,0,0,8'h00, 7'b1011010,8'h00,8'h0A));
      // Write 10, then read it back. Rd_valid shows up three edges after
      // the decision cycle, i.e. in the fourth cycle counting the decision.
      tbl.push_back(row(0,1,0,8'h10,8'h0C,0,1,0,0,8'h00, 7'b0000000,8'h00,8'h00));
      tbl.push_back(row(0,1,0,8'h10,8'h0C,0,1,0,0,8'h00, 7'b1011010,8'h00,8'h10));
      tbl.push_back(row(0,0,0,8'h10,8'h0C,1,0,0,0,8'h00, 7'b0000000,8'h00,8'h00));
      tbl.push_back(row(0,0,0,8'h10,8'h0C,1,0,0,1,8'h10, 7'b0001010,8'h00,8'h00));
      tbl.push_back(row(0,0,0,8'h10,8'h0C,1,0,0,1,8'h10, 7'b0000010,8'h00,8'h00));
      tbl.push_back(row(0,0,0,8'h10,8'h0C,0,0,0,0,8'h00, 7'b0000011,8'h10,8'h00));
      tbl.push_back(row(0,0,0,8'h10,8'h0C,0,0,0,0,8'h00, 7'b0000000,8'h10,8'h00));
      // Full blocks Req0. When Full drops, the grant follows one cycle later.
      tbl.push_back(row(0,1,0,8'h21,8'h0C,0,0,1,0,8'h00, 7'b0000000,8'h10,8'h00));
      tbl.push_back(row(0,1,0,8'h21,8'h0C,0,0,1,0,8'h00, 7'b0000000,8'h10,8'h00));
      tbl.push_back(row(0,1,0,8'h21,8'h0C,0,0,0,0,8'h00, 7'b0000000,8'h10,8'h00));
      tbl.push_back(row(0,1,0,8'h21,8'h0C,0,0,0,0,8'h00, 7'b1011010,8'h10,8'h21));
      // Read and write both pending: the last serviced was a write, so a
      // read comes first. The next write follows the TURN cycle.
      tbl.push_back(row(0,1,0,8'h33,8'h0C,1,0,0,1,8'h5A, 7'b0000000,8'h10,8'h00));
      tbl.push_back(row(0,1,0,8'h33,8'h0C,1,0,0,1,8'h5A, 7'b0001010,8'h10,8'h00));
      tbl.push_back(row(0,1,0,8'h33,8'h0C,1,0,0,1,8'h5A, 7'b0000010,8'h10,8'h00));
      tbl.push_back(row(0,1,0,8'h33,8'h0C,1,0,0,1,8'h5A, 7'b0000011,8'h5A,8'h00));
      tbl.push_back(row(0,1,0,8'h33,8'h0C,1,0,0,1,8'h5A, 7'b0000000,8'h5A,8'h00));
      tbl.push_back(row(0,1,0,8'h33,8'h0C,1,0,0,1,8'h5A, 7'b1011010,8'h5A,8'h33));
      tbl.push_back(row(0,1,0,8'h33,8'h0C,1,0,0,1,8'h5A, 7'b0000000,8'h5A,8'h00));
      tbl.push_back(row(0,1,0,8'h33,8'h0C,1,0,0,1,8'h5A, 7'b0001010,8'h5A,8'h00));
      tbl.push_back(row(0,1,0,8'h33,8'h0C,1,0,0,1,8'h5A, 7'b0000010,8'h5A,8'h00));
      tbl.push_back(row(0,0,0,8'h33,8'h0C,0,0,0,0,8'h00, 7'b0000011,8'h5A,8'h00));
      tbl.push_back(row(0,0,0,8'h33,8'h0C,0,0,0,0,8'h00, 7'b0000000,8'h5A,8'h00));
      // Req1 is withdrawn before its grant: nothing happens.
      // The pointer still favours producer 1 afterwards.
      tbl.push_back(row(0,0,1,8'h33,8'h44,0,0,0,0,8'h00, 7'b0000000,8'h5A,8'h00));
      tbl.push_back(row(0,0,0,8'h33,8'h44,0,0,0,0,8'h00, 7'b0000010,8'h5A,8'h00));
      tbl.push_back(row(0,1,1,8'h33,8'h44,0,0,0,0,8'h00, 7'b0000000,8'h5A,8'h00));
      tbl.push_back(row(0,1,1,8'h33,8'h44,0,0,0,0,8'h00, 7'b0111010,8'h5A,8'h44));
      tbl.push_back(row(0,0,0,8'h33,8'h44,0,0,0,0,8'h00, 7'b0000000,8'h5A,8'h00));
      // Clr while idle: one INIT cycle with Load, then idle again.
      tbl.push_back(row(1,0,0,8'h00,8'h00,0,0,0,0,8'h00, 7'b0000000,8'h5A,8'h00));
      tbl.push_back(row(0,0,0,8'h00,8'h00,0,0,0,0,8'h00, 7'b0000110,8'h5A,8'h00));
      tbl.push_back(row(0,0,0,8'h00,8'h00,0,0,0,0,8'h00, 7'b0000000,8'h5A,8'h00));
      // Empty blocks Rd_req until it drops.
      tbl.push_back(row(0,0,0,8'h00,8'h00,1,1,0,0,8'h00, 7'b0000000,8'h5A,8'h00));
      tbl.push_back(row(0,0,0,8'h00,8'h00,1,0,0,1,8'h77, 7'b0000000,8'h5A,8'h00));
      tbl.push_back(row(0,0,0,8'h00,8'h00,1,0,0,1,8'h77, 7'b0001010,8'h5A,8'h00));
      tbl.push_back(row(0,0,0,8'h00,8'h00,0,0,0,1,8'h77, 7'b0000010,8'h5A,8'h00));
      tbl.push_back(row(0,0,0,8'h00,8'h00,0,0,0,0,8'h00, 7'b0000011,8'h77,8'h00));
      tbl.push_back(row(0,0,0,8'h00,8'h00,0,0,0,0,8'h00, 7'b0000000,8'h77,8'h00));

      doReset();

      foreach (tbl[i]) begin
         @(negedge Clk);
         applyStimulus(tbl[i]);
         #1;
         checkOutput(tbl[i], i);
      end

      // Reset in the middle of a WRITE: the bus is released at once, no
      // grant is issued, and INIT follows the release.
      @(negedge Clk);
      idleInputs();
      bus_if.Req0  = 1'b1;
      bus_if.Data0 = 8'h55;
      #1;
      check("wrst_idle", {31'd0, bus_if.Busy}, 32'd0);
      @(negedge Clk);
      #1;
      check("wrst_in_write", {30'd0, bus_if.Gnt0, bus_if.RW}, 32'd3);
      Rst_n = 1'b0;
      #1;
      check("wrst_abort",
            {25'd0, bus_if.Gnt0, bus_if.Gnt1, bus_if.RW, bus_if.RW1,
             bus_if.Load, bus_if.Busy, bus_if.Rd_valid},
            {25'd0, 7'b0000010});
      check("wrst_rd_data", {24'd0, bus_if.Rd_data}, 32'd0);
      bus_if.Req0 = 1'b0;
      @(negedge Clk);
      #1;
      check("wrst_held", {30'd0, bus_if.Gnt0, bus_if.RW}, 32'd0);
      Rst_n = 1'b1;
      #1;
      check("wrst_init_load", {31'd0, bus_if.Load}, 32'd1);
      @(negedge Clk);
      #1;
      check("wrst_back_idle", {30'd0, bus_if.Load, bus_if.Busy}, 32'd0);

      // Clr raised during READ: the read completes with Rd_valid, and INIT
      // follows at the next IDLE decision.
      @(negedge Clk);
      bus_if.Rd_req = 1'b1;
      bus_if.Empty  = 1'b0;
      fifo_drv      = 1'b1;
      fifo_word     = 8'h99;
      #1;
      check("clrrd_idle", {31'd0, bus_if.Busy}, 32'd0);
      @(negedge Clk);
      bus_if.Clr = 1'b1;
      #1;
      check("clrrd_read", {30'd0, bus_if.RW, bus_if.RW1}, 32'd1);
      @(negedge Clk);
      #1;
      check("clrrd_cap", {29'd0, bus_if.RW, bus_if.RW1, bus_if.Busy}, 32'd1);
      @(negedge Clk);
      bus_if.Rd_req = 1'b0;
      #1;
      check("clrrd_valid", {31'd0, bus_if.Rd_valid}, 32'd1);
      check("clrrd_data", {24'd0, bus_if.Rd_data}, 32'h99);
      @(negedge Clk);
      #1;
      check("clrrd_idle2", {29'd0, bus_if.Load, bus_if.Busy, bus_if.Rd_valid}, 32'd0);
      @(negedge Clk);
      bus_if.Clr = 1'b0;
      fifo_drv   = 1'b0;
      #1;
      check("clrrd_init", {30'd0, bus_if.Load, bus_if.Busy}, 32'd3);
      @(negedge Clk);
      #1;
      check("clrrd_done", {30'd0, bus_if.Load, bus_if.Busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
